// File: rtl/mixer_pkg.sv
// Shared constants and helpers for the mixer gain slewer.
// Channel order matches the waveform_mixer gain_* ports.
package mixer_pkg;

   localparam int NUM_MIX_CH = 6;
   localparam int GAIN_W     = 8;

   typedef enum logic [2:0] {
      CH_SQUARE    = 3'd0,
      CH_SAWTOOTH  = 3'd1,
      CH_TRIANGLE  = 3'd2,
      CH_SINE      = 3'd3,
      CH_NOISE     = 3'd4,
      CH_WAVETABLE = 3'd5
   } mix_ch_e;

   // Target the slew actually chases: zero while muted.
   function automatic logic [GAIN_W-1:0] eff_tgt(
      input logic              mute,
      input logic [GAIN_W-1:0] tgt
   );
      return mute ? '0 : tgt;
   endfunction

endpackage

// File: rtl/gain_slew_chan.sv
// One channel: stored target, live gain and clamped step toward
// the effective target. Mismatch flag looks at next-state values.
module gain_slew_chan
   import mixer_pkg::*;
#(
   parameter int STEP_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_tick,
   input  logic [STEP_W-1:0] i_step,
   input  logic              i_wr,
   input  logic              i_imm,
   input  logic [GAIN_W-1:0] i_wdata,
   input  logic              i_mute,
   output logic [GAIN_W-1:0] o_cur,
   output logic              o_mismatch
);

   localparam int DW = GAIN_W + 1;

   logic [GAIN_W-1:0] r_tgt;
   logic [GAIN_W-1:0] r_cur;
   logic [GAIN_W-1:0] w_eff;
   logic [DW-1:0]     w_diff;
   logic [DW-1:0]     w_mag;
   logic [DW-1:0]     w_stepx;
   logic [GAIN_W-1:0] w_step8;
   logic [GAIN_W-1:0] w_stepped;
   logic [GAIN_W-1:0] w_cur_nxt;
   logic [GAIN_W-1:0] w_tgt_nxt;

   assign w_eff   = eff_tgt(i_mute, r_tgt);
   assign w_diff  = {1'b0, w_eff} - {1'b0, r_cur};
   assign w_mag   = w_diff[DW-1] ? (~w_diff + DW'(1)) : w_diff;
   assign w_stepx = DW'(i_step);
   assign w_step8 = GAIN_W'(i_step);

   // Clamp to the target when within one step, so no overshoot or wrap.
   always_comb begin
      w_stepped = r_cur;
      if (w_mag <= w_stepx) begin
         w_stepped = w_eff;
      end else if (w_diff[DW-1]) begin
         w_stepped = r_cur - w_step8;
      end else begin
         w_stepped = r_cur + w_step8;
      end
   end

   // Immediate write overrides any same-cycle step; the step sees the old target.
   always_comb begin
      w_cur_nxt = r_cur;
      w_tgt_nxt = r_tgt;
      if (i_wr) begin
         w_tgt_nxt = i_wdata;
      end
      if (i_wr && i_imm) begin
         w_cur_nxt = eff_tgt(i_mute, i_wdata);
      end else if (i_tick) begin
         w_cur_nxt = w_stepped;
      end
   end

   assign o_mismatch = (w_cur_nxt != eff_tgt(i_mute, w_tgt_nxt));
   assign o_cur      = r_cur;

   // Target and live gain registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tgt <= '0;
         r_cur <= '0;
      end else begin
         r_tgt <= w_tgt_nxt;
         r_cur <= w_cur_nxt;
      end
   end

endmodule

// File: rtl/mixer_gain_slewer.sv
// Gain slewer for waveform_mixer: prescaler, write decode, status.
// Optional mute port enabled by defining MIXER_GAIN_MUTE_EN.
module mixer_gain_slewer
   import mixer_pkg::*;
#(
   parameter int DIV_W  = 16,
   parameter int STEP_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [2:0]        wr_ch,
   input  logic [GAIN_W-1:0] wr_data,
   input  logic              wr_immediate,
   input  logic [DIV_W-1:0]  tick_div,
   input  logic [STEP_W-1:0] step,
`ifdef MIXER_GAIN_MUTE_EN
   input  logic              mute,
`endif
   output logic [GAIN_W-1:0] gain_square,
   output logic [GAIN_W-1:0] gain_sawtooth,
   output logic [GAIN_W-1:0] gain_triangle,
   output logic [GAIN_W-1:0] gain_sine,
   output logic [GAIN_W-1:0] gain_noise,
   output logic [GAIN_W-1:0] gain_wavetable,
   output logic              ramping,
   output logic              settled
);

   logic [DIV_W-1:0]      r_cnt;
   logic [DIV_W-1:0]      w_last;
   logic                  w_tick;
   logic                  w_mute;
   logic [NUM_MIX_CH-1:0] w_wr;
   logic [NUM_MIX_CH-1:0] w_mis;
   logic [GAIN_W-1:0]     w_cur [NUM_MIX_CH];
   logic                  r_ramp;
   logic                  r_ramp_d;
   logic                  r_settled;

`ifdef MIXER_GAIN_MUTE_EN
   assign w_mute = mute;
`else
   assign w_mute = 1'b0;
`endif

   // A period of 0 behaves as 1; >= lets a lowered period tick at once.
   assign w_last = (tick_div == '0) ? '0 : (tick_div - DIV_W'(1));
   assign w_tick = (r_cnt >= w_last);

   // Prescaler counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_tick ? '0 : (r_cnt + DIV_W'(1));
      end
   end

   for (genvar i = 0; i < NUM_MIX_CH; i++) begin : g_chan
      assign w_wr[i] = wr_en && (wr_ch == 3'(i));

      gain_slew_chan #(
         .STEP_W (STEP_W)
      ) u_chan (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_tick     (w_tick),
         .i_step     (step),
         .i_wr       (w_wr[i]),
         .i_imm      (wr_immediate),
         .i_wdata    (wr_data),
         .i_mute     (w_mute),
         .o_cur      (w_cur[i]),
         .o_mismatch (w_mis[i])
      );
   end

   // Ramping status, its delayed copy, and the settled pulse after the fall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ramp    <= 1'b0;
         r_ramp_d  <= 1'b0;
         r_settled <= 1'b0;
      end else begin
         r_ramp    <= |w_mis;
         r_ramp_d  <= r_ramp;
         r_settled <= r_ramp_d & ~r_ramp;
      end
   end

   assign gain_square    = w_cur[CH_SQUARE];
   assign gain_sawtooth  = w_cur[CH_SAWTOOTH];
   assign gain_triangle  = w_cur[CH_TRIANGLE];
   assign gain_sine      = w_cur[CH_SINE];
   assign gain_noise     = w_cur[CH_NOISE];
   assign gain_wavetable = w_cur[CH_WAVETABLE];
   assign ramping        = r_ramp;
   assign settled        = r_settled;

endmodule
